// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM/WB bus for the MEM pipeline stage.
// The EX side (master) drives the in_* signals and observes the registered out_* signals
// presented to writeback; the MEM stage itself is the slave.
interface mem_stage_if;
  logic        in_valid;
  logic [31:0] in_alu_result;
  logic [31:0] in_write_data;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [1:0]  in_mem_size;
  logic        in_mem_unsigned;
  logic        in_mem_to_reg;
  logic        in_reg_write;
  logic [4:0]  in_write_reg;
  logic        in_stall;
  logic        in_flush;

  logic        out_valid;
  logic [31:0] out_address;
  logic [31:0] out_read_data;
  logic        out_mem_to_reg;
  logic        out_reg_write;
  logic [4:0]  out_write_reg;
  logic        out_misaligned;

  modport master (
    output in_valid, in_alu_result, in_write_data, in_mem_read, in_mem_write,
           in_mem_size, in_mem_unsigned, in_mem_to_reg, in_reg_write, in_write_reg,
           in_stall, in_flush,
    input  out_valid, out_address, out_read_data, out_mem_to_reg, out_reg_write,
           out_write_reg, out_misaligned
  );

  modport slave (
    input  in_valid, in_alu_result, in_write_data, in_mem_read, in_mem_write,
           in_mem_size, in_mem_unsigned, in_mem_to_reg, in_reg_write, in_write_reg,
           in_stall, in_flush,
    output out_valid, out_address, out_read_data, out_mem_to_reg, out_reg_write,
           out_write_reg, out_misaligned
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: word-organised little-endian data memory with byte/half/word
// loads and stores, sign/zero extension, misalignment detection, and the MEM/WB
// pipeline register. Loads read the memory contents from before a same-edge store.
module mem_stage #(
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = 10
) (
  input  logic      clk,
  input  logic      rst,
  mem_stage_if.slave bus
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  // Extract the addressed lane(s) from a memory word and extend to 32 bits.
  function automatic logic [31:0] load_extract(
    input logic [31:0] word,
    input logic [1:0]  lo,
    input logic [1:0]  size,
    input logic        uns
  );
    logic [31:0] shifted;
    shifted = word >> {lo, 3'b000};
    case (size)
      SIZE_BYTE: load_extract = uns ? {24'h000000, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_extract = uns ? {16'h0000, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
      default:   load_extract = word;
    endcase
  endfunction

  // Byte-lane enables for a store of the given size at the given low address bits.
  function automatic logic [3:0] store_lanes(input logic [1:0] lo, input logic [1:0] size);
    case (size)
      SIZE_BYTE: store_lanes = 4'b0001 << lo;
      SIZE_HALF: store_lanes = lo[1] ? 4'b1100 : 4'b0011;
      default:   store_lanes = 4'b1111;
    endcase
  endfunction

  // Replicate store data so each enabled lane sees its byte in place.
  function automatic logic [31:0] store_data(input logic [31:0] wd, input logic [1:0] size);
    case (size)
      SIZE_BYTE: store_data = {4{wd[7:0]}};
      SIZE_HALF: store_data = {2{wd[15:0]}};
      default:   store_data = wd;
    endcase
  endfunction

  // Misalignment of the raw address for the requested size (byte never misaligns).
  function automatic logic misalign_raw(input logic [1:0] lo, input logic [1:0] size);
    case (size)
      SIZE_BYTE: misalign_raw = 1'b0;
      SIZE_HALF: misalign_raw = lo[0];
      default:   misalign_raw = (lo != 2'b00);
    endcase
  endfunction

  logic [31:0] r_mem [DEPTH];

  logic        r_valid;
  logic [31:0] r_address;
  logic [31:0] r_read_data;
  logic        r_mem_to_reg;
  logic        r_reg_write;
  logic [4:0]  r_write_reg;
  logic        r_misaligned;

  logic [ADDR_BITS-1:0] w_idx;
  logic [1:0]           w_lo;
  logic                 w_mem_op;
  logic                 w_misaligned;
  logic                 w_effective;
  logic                 w_load;
  logic                 w_store;
  logic [3:0]           w_lanes;
  logic [31:0]          w_wdata;
  logic [31:0]          w_old_word;
  logic [31:0]          w_read_data;

  assign w_idx = bus.in_alu_result[ADDR_BITS+1:2];
  assign w_lo  = bus.in_alu_result[1:0];

  // Classify the access: misalignment only matters for real memory instructions.
  always_comb begin
    w_mem_op     = 1'b0;
    w_misaligned = 1'b0;
    w_effective  = 1'b0;
    w_load       = 1'b0;
    w_store      = 1'b0;
    if (bus.in_valid) begin
      w_mem_op     = bus.in_mem_read | bus.in_mem_write;
      w_misaligned = w_mem_op & misalign_raw(w_lo, bus.in_mem_size);
      w_effective  = w_mem_op & ~w_misaligned;
      w_load       = w_effective & bus.in_mem_read;
      // Stores only commit when the stage actually advances.
      w_store      = w_effective & bus.in_mem_write & ~bus.in_flush & ~bus.in_stall;
    end else begin
      w_mem_op     = 1'b0;
    end
  end

  assign w_lanes    = store_lanes(w_lo, bus.in_mem_size);
  assign w_wdata    = store_data(bus.in_write_data, bus.in_mem_size);
  assign w_old_word = r_mem[w_idx];

  // Load data from the pre-store word; zero whenever no effective load happens.
  always_comb begin
    w_read_data = 32'h00000000;
    if (w_load) begin
      w_read_data = load_extract(w_old_word, w_lo, bus.in_mem_size, bus.in_mem_unsigned);
    end else begin
      w_read_data = 32'h00000000;
    end
  end

  // Byte-lane store into data memory; an edge seen while rst is high never writes,
  // and the memory contents themselves are never cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
    end else if (w_store) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lanes[i]) begin
          r_mem[w_idx][i*8 +: 8] <= w_wdata[i*8 +: 8];
        end
      end
    end
  end

  // MEM/WB pipeline register: flush beats stall beats advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_address    <= 32'h00000000;
      r_read_data  <= 32'h00000000;
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_write_reg  <= 5'd0;
      r_misaligned <= 1'b0;
    end else if (bus.in_flush) begin
      r_valid      <= 1'b0;
      r_address    <= 32'h00000000;
      r_read_data  <= 32'h00000000;
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_write_reg  <= 5'd0;
      r_misaligned <= 1'b0;
    end else if (bus.in_stall) begin
      r_valid      <= r_valid;
      r_address    <= r_address;
      r_read_data  <= r_read_data;
      r_mem_to_reg <= r_mem_to_reg;
      r_reg_write  <= r_reg_write;
      r_write_reg  <= r_write_reg;
      r_misaligned <= r_misaligned;
    end else begin
      r_valid      <= bus.in_valid;
      r_address    <= bus.in_alu_result;
      r_read_data  <= w_read_data;
      r_mem_to_reg <= bus.in_valid & bus.in_mem_to_reg;
      r_reg_write  <= bus.in_valid & bus.in_reg_write & ~w_misaligned;
      r_write_reg  <= bus.in_write_reg;
      r_misaligned <= w_misaligned;
    end
  end

  assign bus.out_valid      = r_valid;
  assign bus.out_address    = r_address;
  assign bus.out_read_data  = r_read_data;
  assign bus.out_mem_to_reg = r_mem_to_reg;
  assign bus.out_reg_write  = r_reg_write;
  assign bus.out_write_reg  = r_write_reg;
  assign bus.out_misaligned = r_misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: loads/stores of all sizes, extension,
// misalignment, stall/flush priority, address wrap, pass-through and async reset.
module tb_mem_stage;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  mem_stage_if bus ();

  mem_stage #(.DEPTH(1024), .ADDR_BITS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] wd,
                       input logic rd, input logic wr, input logic [1:0] sz, input logic u,
                       input logic m2r, input logic rw, input logic [4:0] wreg);
    bus.in_valid        = v;
    bus.in_alu_result   = a;
    bus.in_write_data   = wd;
    bus.in_mem_read     = rd;
    bus.in_mem_write    = wr;
    bus.in_mem_size     = sz;
    bus.in_mem_unsigned = u;
    bus.in_mem_to_reg   = m2r;
    bus.in_reg_write    = rw;
    bus.in_write_reg    = wreg;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
    drive(1'b1, a, wd, 1'b0, 1'b1, sz, 1'b0, 1'b0, 1'b0, 5'd0);
    step();
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic u);
    drive(1'b1, a, 32'h00000000, 1'b1, 1'b0, sz, u, 1'b1, 1'b1, 5'd8);
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_stall = 1'b0;
    bus.in_flush = 1'b0;
    drive(1'b1, 32'h00000010, 32'h12345678, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 5'd3);
    step();
    step();
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out_read_data !== 32'h0) $display("FAIL reset_rdata: got %h exp 0", bus.out_read_data); else pass_cnt++;
    total_cnt++; if ({bus.out_address, bus.out_reg_write, bus.out_mem_to_reg, bus.out_write_reg, bus.out_misaligned} !== 40'h0)
      $display("FAIL reset_other: got addr %h rw %b m2r %b wr %0d mis %b exp all 0", bus.out_address,
               bus.out_reg_write, bus.out_mem_to_reg, bus.out_write_reg, bus.out_misaligned); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_word();
    store(32'h00000010, 32'hDEADBEEF, 2'b10);
    load(32'h00000010, 2'b10, 1'b0);
    total_cnt++; if (bus.out_read_data !== 32'hDEADBEEF) $display("FAIL lw_data: got %h exp deadbeef", bus.out_read_data); else pass_cnt++;
    total_cnt++; if ({bus.out_valid, bus.out_mem_to_reg, bus.out_reg_write} !== 3'b111)
      $display("FAIL lw_ctrl: got %b exp 111", {bus.out_valid, bus.out_mem_to_reg, bus.out_reg_write}); else pass_cnt++;
    total_cnt++; if (bus.out_address !== 32'h10 || bus.out_write_reg !== 5'd8)
      $display("FAIL lw_addr: got %h/%0d exp 10/8", bus.out_address, bus.out_write_reg); else pass_cnt++;
  endtask

  task automatic test_byte();
    store(32'h00000020, 32'h11223344, 2'b10);
    store(32'h00000021, 32'h000000AA, 2'b00);
    load(32'h00000020, 2'b10, 1'b0);
    total_cnt++; if (bus.out_read_data !== 32'h1122AA44) $display("FAIL sb_merge: got %h exp 1122aa44", bus.out_read_data); else pass_cnt++;
    load(32'h00000021, 2'b00, 1'b0);
    total_cnt++; if (bus.out_read_data !== 32'hFFFFFFAA) $display("FAIL lb_sign: got %h exp ffffffaa", bus.out_read_data); else pass_cnt++;
    load(32'h00000021, 2'b00, 1'b1);
    total_cnt++; if (bus.out_read_data !== 32'h000000AA) $display("FAIL lbu_zero: got %h exp 000000aa", bus.out_read_data); else pass_cnt++;
    load(32'h00000023, 2'b00, 1'b0);
    total_cnt++; if (bus.out_read_data !== 32'h00000011) $display("FAIL lb_lane3: got %h exp 00000011", bus.out_read_data); else pass_cnt++;
  endtask

  task automatic test_half();
    store(32'h00000030, 32'h00000000, 2'b10);
    store(32'h00000032, 32'h00008001, 2'b01);
    load(32'h00000032, 2'b01, 1'b0);
    total_cnt++; if (bus.out_read_data !== 32'hFFFF8001) $display("FAIL lh_sign: got %h exp ffff8001", bus.out_read_data); else pass_cnt++;
    load(32'h00000032, 2'b01, 1'b1);
    total_cnt++; if (bus.out_read_data !== 32'h00008001) $display("FAIL lhu_zero: got %h exp 00008001", bus.out_read_data); else pass_cnt++;
    load(32'h00000031, 2'b10, 1'b0);
    total_cnt++; if (bus.out_misaligned !== 1'b1 || bus.out_reg_write !== 1'b0 || bus.out_valid !== 1'b1)
      $display("FAIL lw_misalign: got mis %b rw %b v %b exp 1 0 1", bus.out_misaligned, bus.out_reg_write, bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out_read_data !== 32'h0) $display("FAIL misalign_rdata: got %h exp 0", bus.out_read_data); else pass_cnt++;
    store(32'h00000031, 32'hFFFFFFFF, 2'b10);
    store(32'h00000033, 32'h0000FFFF, 2'b01);
    load(32'h00000030, 2'b10, 1'b0);
    total_cnt++; if (bus.out_read_data !== 32'h80010000) $display("FAIL misalign_nostore: got %h exp 80010000", bus.out_read_data); else pass_cnt++;
    total_cnt++; if (bus.out_misaligned !== 1'b0) $display("FAIL mis_clear: got %b exp 0", bus.out_misaligned); else pass_cnt++;
  endtask

  task automatic test_stall_flush();
    store(32'h00000040, 32'h12345678, 2'b10);
    load(32'h00000010, 2'b10, 1'b0);
    drive(1'b1, 32'h00000040, 32'hCAFEF00D, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 5'd0);
    bus.in_stall = 1'b1;
    step();
    total_cnt++; if (bus.out_read_data !== 32'hDEADBEEF || bus.out_address !== 32'h10 || bus.out_mem_to_reg !== 1'b1)
      $display("FAIL stall_hold: got %h@%h m2r %b exp deadbeef@10 m2r 1", bus.out_read_data, bus.out_address, bus.out_mem_to_reg); else pass_cnt++;
    bus.in_flush = 1'b1;
    step();
    total_cnt++; if (bus.out_valid !== 1'b0 || bus.out_address !== 32'h0 || bus.out_read_data !== 32'h0 || bus.out_reg_write !== 1'b0)
      $display("FAIL flush_bubble: got v %b addr %h rd %h rw %b exp all 0", bus.out_valid, bus.out_address, bus.out_read_data, bus.out_reg_write); else pass_cnt++;
    bus.in_stall = 1'b0;
    bus.in_flush = 1'b0;
    load(32'h00000040, 2'b10, 1'b0);
    total_cnt++; if (bus.out_read_data !== 32'h12345678) $display("FAIL stall_nostore: got %h exp 12345678", bus.out_read_data); else pass_cnt++;
  endtask

  task automatic test_bubble_wrap_rtype();
    store(32'h00000050, 32'h11111111, 2'b10);
    drive(1'b0, 32'h00000050, 32'h22222222, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 5'd4);
    step();
    total_cnt++; if ({bus.out_valid, bus.out_reg_write, bus.out_mem_to_reg, bus.out_misaligned} !== 4'b0000)
      $display("FAIL bubble_ctrl: got %b exp 0000", {bus.out_valid, bus.out_reg_write, bus.out_mem_to_reg, bus.out_misaligned}); else pass_cnt++;
    load(32'h00000050, 2'b10, 1'b0);
    total_cnt++; if (bus.out_read_data !== 32'h11111111) $display("FAIL bubble_nostore: got %h exp 11111111", bus.out_read_data); else pass_cnt++;
    store(32'h00001000, 32'h00000005, 2'b10);
    load(32'h00000000, 2'b10, 1'b0);
    total_cnt++; if (bus.out_read_data !== 32'h00000005) $display("FAIL addr_wrap: got %h exp 00000005", bus.out_read_data); else pass_cnt++;
    drive(1'b1, 32'h00000007, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 5'd3);
    step();
    total_cnt++; if (bus.out_address !== 32'h7 || bus.out_read_data !== 32'h0 || bus.out_misaligned !== 1'b0)
      $display("FAIL rtype_pass: got addr %h rd %h mis %b exp 7 0 0", bus.out_address, bus.out_read_data, bus.out_misaligned); else pass_cnt++;
    total_cnt++; if (bus.out_reg_write !== 1'b1 || bus.out_write_reg !== 5'd3 || bus.out_mem_to_reg !== 1'b0)
      $display("FAIL rtype_ctrl: got rw %b wr %0d m2r %b exp 1 3 0", bus.out_reg_write, bus.out_write_reg, bus.out_mem_to_reg); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    store(32'h00000060, 32'hAAAA5555, 2'b10);
    drive(1'b1, 32'h00000060, 32'h01020304, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 5'd9);
    step();
    total_cnt++; if (bus.out_read_data !== 32'hAAAA5555) $display("FAIL read_old: got %h exp aaaa5555", bus.out_read_data); else pass_cnt++;
    load(32'h00000060, 2'b10, 1'b0);
    total_cnt++; if (bus.out_read_data !== 32'h01020304) $display("FAIL rw_store: got %h exp 01020304", bus.out_read_data); else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    store(32'h00000070, 32'h00000000, 2'b10);
    load(32'h00000010, 2'b10, 1'b0);
    drive(1'b1, 32'h00000070, 32'h00000099, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 5'd0);
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (bus.out_read_data !== 32'h0 || bus.out_valid !== 1'b0 || bus.out_address !== 32'h0)
      $display("FAIL rst_async: got rd %h v %b addr %h exp 0 0 0", bus.out_read_data, bus.out_valid, bus.out_address); else pass_cnt++;
    step();
    #2 rst = 1'b0;
    load(32'h00000070, 2'b10, 1'b0);
    total_cnt++; if (bus.out_read_data !== 32'h0) $display("FAIL rst_store_lost: got %h exp 0", bus.out_read_data); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL rst_resume: got %b exp 1", bus.out_valid); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_stall_flush();
    test_bubble_wrap_rtype();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
